adc_sample_stats: RTL and testbench

ADC_SAMPLE_STATS -- requirements
Module: adc_sample_stats

---
 rtl/adc_sample_stats.sv | 146 ++++++++++++++
 tb/tb_adc_sample_stats.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_sample_stats.sv
// adc_sample_stats: running min/max/sum/count/over-threshold statistics on
// ADC sample strobes, exposed as OPB registers, with a completion interrupt.
//
// Ports:
//   OPB_CLK, OPB_RST          clock, synchronous active-high reset
//   OPB_ADDR/DI/WE/RE/DO      register bus (DO is 'z when not addressed)
//   SMP_DATA, SMP_VALID       sample word and its one-cycle strobe
//   SMP_DONE                  acquisition-complete level
//   STAT_IRQ                  one-cycle pulse when statistics are final
module adc_sample_stats #(
  parameter bit          SIGNED    = 1'b0,
  parameter logic [11:0] BASE_ADDR = 12'h810
) (
  input  logic        OPB_CLK,
  input  logic        OPB_RST,
  input  logic [11:0] OPB_ADDR,
  input  logic [15:0] OPB_DI,
  input  logic        OPB_WE,
  input  logic        OPB_RE,
  output logic [31:0] OPB_DO,
  input  logic [15:0] SMP_DATA,
  input  logic        SMP_VALID,
  input  logic        SMP_DONE,
  output logic        STAT_IRQ
);

  typedef enum logic [1:0] {IDLE, ARMED, ACCUM, DONE} state_e;

  localparam logic [15:0] MIN_INIT = SIGNED ? 16'h7FFF : 16'hFFFF;
  localparam logic [15:0] MAX_INIT = SIGNED ? 16'h8000 : 16'h0000;

  state_e      state_q, state_d;
  logic        arm_q;
  logic [15:0] thresh_q, min_q, max_q;
  logic [27:0] sum_q;
  logic [11:0] count_q, over_q;
  logic        late_q, done_prev_q, irq_q, irq_d;

  logic [11:0] off;
  logic        hit, wr_ctrl, wr_thr;
  logic        clr, arm, done_rise, active, take;
  logic [27:0] smp_ext;
  logic [31:0] rdata;

  function automatic logic lt(input logic [15:0] a,
                              input logic [15:0] b);
    if (SIGNED) return $signed(a) < $signed(b);
    return a < b;
  endfunction

  assign off     = OPB_ADDR - BASE_ADDR;
  assign hit     = (off[11:3] == 9'd0);
  assign wr_ctrl = OPB_WE && hit && (off[2:0] == 3'd0);
  assign wr_thr  = OPB_WE && hit && (off[2:0] == 3'd5);

  // clear outranks arm when both bits are written together
  assign clr = wr_ctrl && OPB_DI[1];
  assign arm = wr_ctrl && OPB_DI[0] && !OPB_DI[1];

  assign done_rise = SMP_DONE && !done_prev_q;

  // a saturated count freezes every statistic
  assign take = active && SMP_VALID && (count_q != 12'hFFF);

  assign smp_ext = SIGNED ? {{12{SMP_DATA[15]}}, SMP_DATA}
                          : {12'd0, SMP_DATA};

  always_ff @(posedge OPB_CLK) begin
    if (OPB_RST) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (arm) state_d = ARMED;
      ARMED: begin
        if (done_rise)      state_d = DONE;
        else if (SMP_VALID) state_d = ACCUM;
      end
      ACCUM: if (done_rise) state_d = DONE;
      DONE:  if (arm) state_d = ARMED;
    endcase
    if (clr) state_d = IDLE;
  end

  always_comb begin
    active = (state_q == ARMED) || (state_q == ACCUM);
    irq_d  = (state_d == DONE) && (state_q != DONE);
    rdata  = '0;
    unique case (off[2:0])
      3'd0: rdata = {31'd0, arm_q};
      3'd1: rdata = {16'd0, min_q};
      3'd2: rdata = {16'd0, max_q};
      3'd3: rdata = {4'd0, sum_q};
      3'd4: rdata = {20'd0, count_q};
      3'd5: rdata = {16'd0, thresh_q};
      3'd6: rdata = {20'd0, over_q};
      3'd7: rdata = {28'd0, late_q, (count_q == 12'hFFF),
                     (state_q == DONE), active};
    endcase
  end

  assign OPB_DO   = (OPB_RE && hit) ? rdata : 32'bz;
  assign STAT_IRQ = irq_q;

  always_ff @(posedge OPB_CLK) begin
    if (OPB_RST) begin
      arm_q       <= 1'b0;
      thresh_q    <= 16'h0000;
      min_q       <= MIN_INIT;
      max_q       <= MAX_INIT;
      sum_q       <= '0;
      count_q     <= '0;
      over_q      <= '0;
      late_q      <= 1'b0;
      done_prev_q <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      done_prev_q <= SMP_DONE;
      irq_q       <= irq_d;
      if (wr_thr) thresh_q <= OPB_DI;
      if (clr || (arm && !active)) begin
        arm_q   <= !clr;
        min_q   <= MIN_INIT;
        max_q   <= MAX_INIT;
        sum_q   <= '0;
        count_q <= '0;
        over_q  <= '0;
        late_q  <= 1'b0;
      end else begin
        if (take) begin
          sum_q   <= sum_q + smp_ext;
          count_q <= count_q + 12'd1;
          if (lt(SMP_DATA, min_q)) min_q <= SMP_DATA;
          if (lt(max_q, SMP_DATA)) max_q <= SMP_DATA;
          if (lt(thresh_q, SMP_DATA) && (over_q != 12'hFFF))
            over_q <= over_q + 12'd1;
        end
        if ((state_q == DONE) && SMP_VALID) late_q <= 1'b1;
        if (irq_d) arm_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_adc_sample_stats.sv
// tb_adc_sample_stats: randomized + directed scoreboard bench for
// adc_sample_stats, one unsigned and one signed instance in parallel.
module tb_adc_sample_stats;

  localparam logic [11:0] BASE = 12'h810;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, we, re, sv, sd;
  logic [11:0] addr;
  logic [15:0] di, sdata;
  tri1  [31:0] do0, do1;
  logic        irq0, irq1;

  adc_sample_stats #(.SIGNED(1'b0), .BASE_ADDR(BASE)) u0 (
    .OPB_CLK(clk), .OPB_RST(rst), .OPB_ADDR(addr), .OPB_DI(di),
    .OPB_WE(we), .OPB_RE(re), .OPB_DO(do0), .SMP_DATA(sdata),
    .SMP_VALID(sv), .SMP_DONE(sd), .STAT_IRQ(irq0));

  adc_sample_stats #(.SIGNED(1'b1), .BASE_ADDR(BASE)) u1 (
    .OPB_CLK(clk), .OPB_RST(rst), .OPB_ADDR(addr), .OPB_DI(di),
    .OPB_WE(we), .OPB_RE(re), .OPB_DO(do1), .SMP_DATA(sdata),
    .SMP_VALID(sv), .SMP_DONE(sd), .STAT_IRQ(irq1));

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string       name;
    logic [31:0] e0;
    logic [31:0] e1;
  } rd_t;
  rd_t rdq[$];
  int  irqq0[$];
  int  irqq1[$];

  // reference model: accepted samples kept as a list
  logic [15:0] smp[$];
  bit          m_active, m_done, m_late, m_prev;
  logic [15:0] m_thr;
  int          over0, over1;

  function automatic int sx(input logic [15:0] v, input bit s);
    if (s) return int'($signed(v));
    return int'({16'd0, v});
  endfunction

  function automatic logic [31:0] exp_min(input bit s);
    int m = s ? 32767 : 65535;
    foreach (smp[i]) if (sx(smp[i], s) < m) m = sx(smp[i], s);
    return 32'(m) & 32'h0000FFFF;
  endfunction

  function automatic logic [31:0] exp_max(input bit s);
    int m = s ? -32768 : 0;
    foreach (smp[i]) if (sx(smp[i], s) > m) m = sx(smp[i], s);
    return 32'(m) & 32'h0000FFFF;
  endfunction

  function automatic logic [31:0] exp_sum(input bit s);
    longint a = 0;
    foreach (smp[i]) a += longint'(sx(smp[i], s));
    return 32'(a & 64'h0FFFFFFF);
  endfunction

  function automatic logic [31:0] exp_reg(input logic [2:0] o,
                                          input bit s);
    logic [31:0] r = '0;
    case (o)
      3'd0: r = {31'd0, m_active};
      3'd1: r = exp_min(s);
      3'd2: r = exp_max(s);
      3'd3: r = exp_sum(s);
      3'd4: r = 32'(smp.size());
      3'd5: r = {16'd0, m_thr};
      3'd6: r = s ? 32'(over1) : 32'(over0);
      default: r = {28'd0, m_late, (smp.size() == 4095),
                    m_done, m_active};
    endcase
    return r;
  endfunction

  function automatic void chk(input string nm, input logic [31:0] a,
                              input logic [31:0] e);
    vectors++;
    if (!((a === e) ||
          (e === 32'hFFFFFFFF && a === 32'bz))) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", nm, a, e);
    end
  endfunction

  // monitor: compare every read and every interrupt pulse
  always @(negedge clk) begin
    rd_t r;
    int  e;
    if (re) begin
      if (rdq.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL rd_unexpected: got %h want none", do0);
      end else begin
        r = rdq.pop_front();
        chk({r.name, "/u"}, do0, r.e0);
        chk({r.name, "/s"}, do1, r.e1);
      end
    end
    if (irq0) begin
      vectors++;
      if (irqq0.size() == 0) begin
        miscompares++;
        $display("FAIL irq_u: got pulse at %0d want none", cyc);
      end else begin
        e = irqq0.pop_front();
        if (e != cyc) begin
          miscompares++;
          $display("FAIL irq_u: got cycle %0d want %0d", cyc, e);
        end
      end
    end
    if (irq1) begin
      vectors++;
      if (irqq1.size() == 0) begin
        miscompares++;
        $display("FAIL irq_s: got pulse at %0d want none", cyc);
      end else begin
        e = irqq1.pop_front();
        if (e != cyc) begin
          miscompares++;
          $display("FAIL irq_s: got cycle %0d want %0d", cyc, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    smp.delete();
    over0 = 0; over1 = 0;
    m_active = 1'b0; m_done = 1'b0; m_late = 1'b0;
  endtask

  task automatic rst_dut();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_clear();
    m_thr = 16'h0000;
    m_prev = 1'b0;
  endtask

  // one bus cycle: optional register write, sample strobe, done level
  task automatic drive(input bit w, input logic [2:0] wo,
                       input logic [15:0] wd, input bit v,
                       input logic [15:0] sdat, input bit d);
    bit pre_active = m_active;
    bit pre_done = m_done;
    bit clr = w && (wo == 3'd0) && wd[1];
    bit arm = w && (wo == 3'd0) && wd[0] && !wd[1];
    bit rise = d && !m_prev;
    m_prev = d;
    if (clr) begin
      model_clear();
    end else if (arm && !pre_active) begin
      model_clear();
      m_active = 1'b1;
    end else begin
      if (v) begin
        if (pre_active && smp.size() < 4095) begin
          smp.push_back(sdat);
          if (sx(sdat, 1'b0) > sx(m_thr, 1'b0)) over0++;
          if (sx(sdat, 1'b1) > sx(m_thr, 1'b1)) over1++;
        end else if (pre_done) begin
          m_late = 1'b1;
        end
      end
      if (rise && pre_active) begin
        m_active = 1'b0;
        m_done = 1'b1;
        irqq0.push_back(cyc + 1);
        irqq1.push_back(cyc + 1);
      end
    end
    if (w && wo == 3'd5) m_thr = wd;
    we = w; addr = BASE + {9'd0, wo}; di = wd;
    sv = v; sdata = sdat; sd = d;
    tick();
    we = 1'b0; sv = 1'b0; sd = 1'b0;
  endtask

  task automatic idle();
    drive(1'b0, 3'd0, 16'h0, 1'b0, 16'h0, 1'b0);
  endtask

  task automatic smp1(input logic [15:0] v);
    drive(1'b0, 3'd0, 16'h0, 1'b1, v, 1'b0);
  endtask

  task automatic wr(input logic [2:0] o, input logic [15:0] v);
    drive(1'b1, o, v, 1'b0, 16'h0, 1'b0);
  endtask

  task automatic issue_rd(input logic [11:0] a, input rd_t r);
    rdq.push_back(r);
    re = 1'b1; addr = a;
    m_prev = 1'b0;
    tick();
    re = 1'b0;
  endtask

  task automatic rd(input logic [11:0] a, input string nm);
    rd_t r;
    logic [11:0] o = a - BASE;
    r.name = nm;
    if (o < 12'd8) begin
      r.e0 = exp_reg(o[2:0], 1'b0);
      r.e1 = exp_reg(o[2:0], 1'b1);
    end else begin
      r.e0 = 32'hFFFFFFFF;
      r.e1 = 32'hFFFFFFFF;
    end
    issue_rd(a, r);
  endtask

  task automatic rdk(input logic [2:0] o, input string nm,
                     input logic [31:0] e0, input logic [31:0] e1);
    rd_t r;
    r.name = nm; r.e0 = e0; r.e1 = e1;
    issue_rd(BASE + {9'd0, o}, r);
  endtask

  task automatic irq_drained(input string nm);
    idle(); idle();
    vectors++;
    if (irqq0.size() != 0 || irqq1.size() != 0) begin
      miscompares++;
      $display("FAIL %s: got %0d/%0d pending irqs want 0",
               nm, irqq0.size(), irqq1.size());
      irqq0.delete(); irqq1.delete();
    end
  endtask

  function automatic logic [15:0] rnd16();
    int k = $urandom_range(0, 5);
    case (k)
      0: return 16'h0000;
      1: return 16'hFFFF;
      2: return 16'h7FFF;
      3: return 16'h8000;
      4: return 16'($urandom_range(0, 200));
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

  initial begin
    int n, ev;
    rst = 1'b1; we = 1'b0; re = 1'b0; sv = 1'b0; sd = 1'b0;
    addr = BASE; di = '0; sdata = '0;
    m_prev = 1'b0; m_thr = '0;
    model_clear();
    rst_dut();

    // reset values
    rdk(3'd0, "rst_ctrl", 32'h0, 32'h0);
    rdk(3'd1, "rst_min", 32'hFFFF, 32'h7FFF);
    rdk(3'd2, "rst_max", 32'h0, 32'h8000);
    rdk(3'd3, "rst_sum", 32'h0, 32'h0);
    rdk(3'd5, "rst_thresh", 32'h0, 32'h0);
    rdk(3'd7, "rst_status", 32'h0, 32'h0);

    // basic unsigned run
    wr(3'd5, 16'd100);
    wr(3'd0, 16'h1);
    smp1(16'd50); smp1(16'd200); smp1(16'd100); smp1(16'd7);
    drive(1'b0, 3'd0, 16'h0, 1'b0, 16'h0, 1'b1);
    idle();
    rdk(3'd1, "b_min", 32'd7, 32'd7);
    rdk(3'd2, "b_max", 32'd200, 32'd200);
    rdk(3'd3, "b_sum", 32'd357, 32'd357);
    rdk(3'd4, "b_count", 32'd4, 32'd4);
    rdk(3'd6, "b_over", 32'd1, 32'd1);
    rdk(3'd7, "b_status", 32'h2, 32'h2);
    rdk(3'd0, "b_ctrl", 32'h0, 32'h0);
    irq_drained("b_irq");

    // signed vs unsigned compare and sign extension
    wr(3'd0, 16'h2);
    wr(3'd0, 16'h1);
    smp1(16'hFFFE); smp1(16'h0003);
    rdk(3'd1, "sg_min", 32'h0003, 32'hFFFE);
    rdk(3'd2, "sg_max", 32'hFFFE, 32'h0003);
    rdk(3'd3, "sg_sum", 32'h10001, 32'h0000001);
    rdk(3'd6, "sg_over", 32'd1, 32'd0);
    rdk(3'd7, "sg_status", 32'h1, 32'h1);
    drive(1'b0, 3'd0, 16'h0, 1'b0, 16'h0, 1'b1);
    irq_drained("sg_irq");

    // done rising with the third sample
    wr(3'd0, 16'h1);
    smp1(16'd11); smp1(16'd22);
    drive(1'b0, 3'd0, 16'h0, 1'b1, 16'd33, 1'b1);
    idle();
    rdk(3'd4, "co_count", 32'd3, 32'd3);
    rdk(3'd7, "co_status", 32'h2, 32'h2);
    irq_drained("co_irq");

    // count saturation
    wr(3'd0, 16'h1);
    for (int k = 0; k < 4100; k++) smp1(16'hFFFF);
    rdk(3'd4, "sat_count", 32'hFFF, 32'hFFF);
    rdk(3'd7, "sat_status", 32'h5, 32'h5);
    rdk(3'd3, "sat_sum", 32'hFFEF001, 32'hFFFF001);
    rdk(3'd6, "sat_over", 32'hFFF, 32'h0);
    rdk(3'd1, "sat_min", 32'hFFFF, 32'hFFFF);
    drive(1'b0, 3'd0, 16'h0, 1'b0, 16'h0, 1'b1);
    idle();
    rdk(3'd7, "sat_status2", 32'h6, 32'h6);
    irq_drained("sat_irq");

    // arm+clear together mid-acquisition
    wr(3'd0, 16'h1);
    smp1(16'd1); smp1(16'd2); smp1(16'd3);
    wr(3'd0, 16'h3);
    rdk(3'd4, "clr_count", 32'h0, 32'h0);
    rdk(3'd0, "clr_ctrl", 32'h0, 32'h0);
    rdk(3'd7, "clr_status", 32'h0, 32'h0);
    rdk(3'd5, "clr_thresh", 32'd100, 32'd100);
    drive(1'b0, 3'd0, 16'h0, 1'b0, 16'h0, 1'b1);
    irq_drained("clr_irq");

    // reset mid-acquisition
    wr(3'd0, 16'h1);
    smp1(16'd9); smp1(16'd8);
    rst_dut();
    rdk(3'd5, "mr_thresh", 32'h0, 32'h0);
    rdk(3'd1, "mr_min", 32'hFFFF, 32'h7FFF);
    rdk(3'd2, "mr_max", 32'h0, 32'h8000);
    rdk(3'd4, "mr_count", 32'h0, 32'h0);
    rdk(3'd7, "mr_status", 32'h0, 32'h0);
    drive(1'b0, 3'd0, 16'h0, 1'b0, 16'h0, 1'b1);
    irq_drained("mr_irq");

    // unmapped reads and sample after done
    rdk(3'd0, "um_ctrl", 32'h0, 32'h0);
    rd(BASE + 12'd8, "um_plus8");
    rd(BASE - 12'd1, "um_minus1");
    wr(3'd0, 16'h1);
    smp1(16'd5);
    drive(1'b0, 3'd0, 16'h0, 1'b0, 16'h0, 1'b1);
    idle();
    smp1(16'd9);
    rdk(3'd7, "late_status", 32'hA, 32'hA);
    rdk(3'd4, "late_count", 32'd1, 32'd1);
    rdk(3'd1, "late_min", 32'd5, 32'd5);
    irq_drained("late_irq");

    // randomized runs against the model
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 2) == 0) wr(3'd5, rnd16());
      wr(3'd0, 16'h1);
      n = $urandom_range(0, 24);
      for (int k = 0; k < n; k++) begin
        if ($urandom_range(0, 3) == 0) idle();
        if ($urandom_range(0, 9) == 0)
          drive(1'b1, 3'd5, rnd16(), 1'b1, rnd16(), 1'b0);
        else
          smp1(rnd16());
      end
      ev = $urandom_range(0, 9);
      if (ev == 0) drive(1'b1, 3'd0, 16'h3, 1'b1, rnd16(), 1'b0);
      else if (ev == 1) rst_dut();
      else if (ev < 6) drive(1'b0, 3'd0, 16'h0, 1'b1, rnd16(), 1'b1);
      else drive(1'b0, 3'd0, 16'h0, 1'b0, 16'h0, 1'b1);
      idle();
      n = $urandom_range(0, 2);
      for (int k = 0; k < n; k++) smp1(rnd16());
      if ($urandom_range(0, 3) == 0)
        wr(3'($urandom_range(1, 7)), rnd16());
      for (int o = 0; o < 8; o++)
        rd(BASE + 12'(o), $sformatf("it%0d_r%0d", it, o));
      rd(BASE + 12'd8, $sformatf("it%0d_um", it));
      irq_drained($sformatf("it%0d_irq", it));
    end

    idle(); idle();
    vectors++;
    if (rdq.size() != 0) begin
      miscompares++;
      $display("FAIL rd_drain: got %0d pending want 0", rdq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
